// File: rtl/riscv_next_pc_predictor.sv
// riscv_next_pc_predictor
// Fetch-stage next-PC predictor. It decodes JAL/JALR/conditional branches
// from each fetched instruction and predicts the next PC. Branch direction
// uses static backward-taken/forward-not-taken, and call/return targets come
// from a circular return-address stack (RAS). Results are registered, so the
// prediction for an instruction presented in cycle N appears in cycle N+1.
module riscv_next_pc_predictor #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int RAS_DEPTH   = 8,
    parameter bit STATIC_BTFN = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_ras_clear,
    input  logic [ADDR_WIDTH-1:0]        i_pc,
    input  logic [INSTR_WIDTH-1:0]       i_instr,
    output logic                         o_valid,
    output logic                         o_pred_taken,
    output logic [ADDR_WIDTH-1:0]        o_pred_pc,
    output logic                         o_is_call,
    output logic                         o_is_ret,
    output logic                         o_unknown,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [4:0] REG_X0     = 5'd0;
    localparam logic [4:0] REG_X1     = 5'd1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Stack operation requested by the current instruction.
    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP
    } ras_op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  valid_q,   valid_d;
    logic                  taken_q,   taken_d;
    logic [ADDR_WIDTH-1:0] pred_pc_q, pred_pc_d;
    logic                  call_q,    call_d;
    logic                  ret_q,     ret_d;
    logic                  unknown_q, unknown_d;
    logic [PTR_W-1:0]      ptr_q,     ptr_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [ADDR_WIDTH-1:0] entry_q [RAS_DEPTH];

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_branch;
    logic                  is_call;
    logic                  is_ret;
    logic                  is_swap;
    logic [ADDR_WIDTH-1:0] imm_i;
    logic [ADDR_WIDTH-1:0] imm_b;
    logic [ADDR_WIDTH-1:0] imm_j;
    logic [ADDR_WIDTH-1:0] link;

    // RAS view after an optional same-cycle clear.
    logic [PTR_W-1:0]      ptr_eff;
    logic [PTR_W-1:0]      ptr_top;
    logic [CNT_W-1:0]      count_eff;
    logic                  ras_nonempty;
    logic [ADDR_WIDTH-1:0] ras_top;

    // Prediction for the current input.
    logic                  acc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  pred_unknown;
    ras_op_e               ras_op;

    // RAS write port.
    logic                  ras_we;
    logic [PTR_W-1:0]      ras_waddr;

    assign acc    = i_valid & ~i_stall & ~i_flush;
    assign instr  = i_instr[31:0];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign link   = i_pc + ADDR_WIDTH'(4);

    assign imm_i = {{(ADDR_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_b = {{(ADDR_WIDTH-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(ADDR_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // Classify the instruction; a swap is both a call and a return.
    always_comb begin
        is_jal    = (opcode == OPC_JAL);
        is_jalr   = (opcode == OPC_JALR);
        is_branch = (opcode == OPC_BRANCH);
        is_call   = (is_jal | is_jalr) & (rd == REG_X1);
        is_ret    = is_jalr & (rs1 == REG_X1) & (rd != REG_X1);
        is_swap   = is_jalr & (rd == REG_X1) & (rs1 == REG_X1);
    end

    // Apply a pending clear before anything reads the stack, so a clear and
    // an accepted instruction in the same cycle see an empty RAS.
    always_comb begin
        ptr_eff      = i_ras_clear ? '0 : ptr_q;
        count_eff    = i_ras_clear ? '0 : count_q;
        ptr_top      = ptr_eff - PTR_ONE;
        ras_nonempty = (count_eff != '0);
        ras_top      = entry_q[ptr_top];
    end

    // Target and direction prediction, plus the stack operation it implies.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        pred_taken   = 1'b0;
        pred_pc      = link;
        pred_unknown = 1'b0;
        ras_op       = RAS_NONE;

        if (is_jal) begin
            pred_taken = 1'b1;
            pred_pc    = i_pc + imm_j;
            if (is_call) begin
                ras_op = RAS_PUSH;
            end
        end else if (is_jalr) begin
            if (rs1 == REG_X0) begin
                // Absolute target: fully known at fetch.
                pred_taken = 1'b1;
                pred_pc    = imm_i;
                if (is_call) begin
                    ras_op = RAS_PUSH;
                end
            end else if ((is_ret | is_swap) && ras_nonempty) begin
                pred_taken = 1'b1;
                pred_pc    = (ras_top + imm_i) & ~ADDR_WIDTH'(1);
                ras_op     = is_swap ? RAS_SWAP : RAS_POP;
            end else begin
                // Register-indirect target that the RAS cannot supply.
                pred_unknown = 1'b1;
                if (is_call) begin
                    ras_op = RAS_PUSH;
                end
            end
        end else if (is_branch) begin
            if (STATIC_BTFN && instr[31]) begin
                pred_taken = 1'b1;
                pred_pc    = i_pc + imm_b;
            end
        end
    end

    // Next RAS pointer/occupancy and the write request for the entry array.
    always_comb begin
        ptr_d     = ptr_eff;
        count_d   = count_eff;
        ras_we    = 1'b0;
        ras_waddr = ptr_eff;

        if (acc) begin
            unique case (ras_op)
                RAS_PUSH: begin
                    // When full, the oldest entry is simply overwritten.
                    ras_we    = 1'b1;
                    ras_waddr = ptr_eff;
                    ptr_d     = ptr_eff + PTR_ONE;
                    count_d   = (count_eff == CNT_FULL) ? count_eff
                                                        : count_eff + CNT_ONE;
                end
                RAS_POP: begin
                    ptr_d   = ptr_top;
                    count_d = count_eff - CNT_ONE;
                end
                RAS_SWAP: begin
                    ras_we    = 1'b1;
                    ras_waddr = ptr_top;
                end
                default: begin
                end
            endcase
        end
    end

    // Next output register values; flags drop when nothing is accepted.
    always_comb begin
        valid_d   = acc;
        taken_d   = acc & pred_taken;
        call_d    = acc & is_call;
        ret_d     = acc & (is_ret | is_swap);
        unknown_d = acc & pred_unknown;
        pred_pc_d = acc ? pred_pc : pred_pc_q;
    end

    // Output and RAS control registers: reset wins, a stall freezes all.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            pred_pc_q <= '0;
            call_q    <= 1'b0;
            ret_q     <= 1'b0;
            unknown_q <= 1'b0;
            ptr_q     <= '0;
            count_q   <= '0;
        end else if (!i_stall) begin
            valid_q   <= valid_d;
            taken_q   <= taken_d;
            pred_pc_q <= pred_pc_d;
            call_q    <= call_d;
            ret_q     <= ret_d;
            unknown_q <= unknown_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
        end
    end

    // RAS entry storage.
    always_ff @(posedge i_clk) begin
        // NOTE: the entry array has no reset; occupancy is tracked by
        // count_q, so stale contents are never used as a prediction.
        if (!i_rst && !i_stall && ras_we) begin
            entry_q[ras_waddr] <= link;
        end
    end

    assign o_valid      = valid_q;
    assign o_pred_taken = taken_q;
    assign o_pred_pc    = pred_pc_q;
    assign o_is_call    = call_q;
    assign o_is_ret     = ret_q;
    assign o_unknown    = unknown_q;
    assign o_ras_count  = count_q;

endmodule

// File: doc/riscv_next_pc_predictor.md
Name: riscv_next_pc_predictor

Overview:
Successor to the combinational next-instruction decoder. It decodes JAL/JALR/branch from each fetched instruction, computes a predicted next PC, and keeps a parametrised return-address stack (RAS) for call/return prediction. Branch direction uses optional static backward-taken/forward-not-taken (BTFN). It sits in the fetch stage and feeds the PC mux. Its output is registered, so latency is 1 cycle.

Parameters:
INSTR_WIDTH, 32, instruction width; only bits [31:0] are decoded.
ADDR_WIDTH, 64, PC/target width; all address arithmetic is modulo 2^ADDR_WIDTH.
RAS_DEPTH, 8, number of RAS entries; must be a power of 2 and >= 2.
STATIC_BTFN, 1, 1 = backward branches predicted taken; 0 = all branches predicted not-taken.

Ports:
i_clk  in  1  clock; rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  i_pc/i_instr valid this cycle.
i_stall  in  1  hold: input ignored, outputs and RAS frozen.
i_flush  in  1  squash the current input; no RAS update.
i_ras_clear  in  1  empty the RAS (mispredict recovery).
i_pc  in  ADDR_WIDTH  PC of i_instr.
i_instr  in  INSTR_WIDTH  fetched instruction.
o_valid  out  1  registered result valid.
o_pred_taken  out  1  redirect to o_pred_pc.
o_pred_pc  out  ADDR_WIDTH  predicted next PC; equals pc+4 when not taken.
o_is_call  out  1  instruction classified as call.
o_is_ret  out  1  instruction classified as return.
o_unknown  out  1  JALR target not predictable; fetch must wait for execute.
o_ras_count  out  $clog2(RAS_DEPTH)+1  current RAS occupancy.

Behaviour:
- Reset (i_rst=1 at edge): o_valid, o_pred_taken, o_is_call, o_is_ret and o_unknown = 0; o_pred_pc = 0; RAS pointer and count = 0. RAS entry contents are don't-care. Reset has priority over every other input.
- Accept condition: acc = i_valid & !i_stall & !i_flush.
- i_stall=1: all registers hold, including during i_flush or i_ras_clear. Exception: i_rst.
- i_flush=1 with i_stall=0: o_valid<=0 next cycle; the RAS is not modified by that instruction.
- Decode uses the same opcodes and immediates as the existing decoder. imm_j applies to JAL, imm_i to JALR, imm_b to branches; all are sign-extended to ADDR_WIDTH. Fields: rd=instr[11:7], rs1=instr[19:15]. link = pc+4.
- Call: (JAL or JALR) and rd==x1.
- Return: JALR and rs1==x1 and rd!=x1.
- Swap: JALR and rd==x1 and rs1==x1. Swap asserts both o_is_call and o_is_ret.
- Prediction on an accepted instruction:
  JAL: taken, target = pc+imm_j.
  JALR with rs1==x0: taken, target = imm_i.
  Return or swap with RAS count>0: taken, target = RAS top + imm_i, with bit0 cleared.
  Return with RAS empty: not taken, o_unknown=1.
  Other JALR: not taken, o_unknown=1.
  Branch: if STATIC_BTFN and imm sign=1, taken with target pc+imm_b; otherwise not taken.
  Any other opcode: not taken, o_is_call=o_is_ret=o_unknown=0.
  Not taken: o_pred_pc = pc+4.
- RAS is a circular buffer. ptr points to the next free slot; top = entry[ptr-1].
  Push: entry[ptr]<=link, ptr++, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten.
  Pop (count>0 only): ptr--, count--. Pop on empty: ptr and count unchanged.
  Swap with count>0: top entry <= link; ptr and count unchanged.
  Swap with count==0: not taken, o_unknown=1, and link is pushed.
- i_ras_clear with i_stall=0: ptr=count=0 on the next cycle. If the same cycle also accepts an instruction, the clear is applied first, so the prediction sees an empty RAS. A push in that cycle then yields count=1 with entry[0]=link.
- Registers update only on non-stalled edges. When not accepted, o_valid<=0 and the remaining outputs are don't-care except o_ras_count.
- The same-cycle read of RAS top uses the pre-update state. Back-to-back accepted instructions see the previous update: bypass is via the registered state, with no extra bubble.

Test Plan:
- Reset, then JAL x1,+0x100 at pc=0x1000 -> next cycle: o_valid=1, taken, o_pred_pc=0x1100, o_is_call=1, o_ras_count=1.
- After the above, `jalr x0,0(x1)` at pc=0x1100 -> taken, o_pred_pc=0x1004, o_is_ret=1, o_ras_count=0.
- Ret with RAS empty -> o_pred_taken=0, o_unknown=1, o_pred_pc=pc+4, count stays 0.
- 9 calls at pcs 0x0,0x10,...,0x80 with RAS_DEPTH=8 -> count saturates at 8. Then 8 returns predict 0x84,0x74,...,0x14; a 9th return gives o_unknown=1.
- BEQ imm=-8 at pc=0x2000 -> taken, 0x1FF8. BEQ imm=+8 -> not taken, 0x2004. With STATIC_BTFN=0, both are not taken.
- Call accepted with i_stall=1 -> no output change, count unchanged. Call with i_flush=1 -> o_valid=0, count unchanged. Call with i_ras_clear=1 and count=5 -> count=1.
- i_rst asserted while count=3 -> all outputs 0, count=0 next cycle.
